// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller: sequences FETCH..WB and issues unconditioned write requests.
// Define MC_PERF_CNT_EN to add the CycCnt/RetCnt performance counters.
module mc_ctrl_fsm
`ifdef MC_PERF_CNT_EN
  #(parameter int unsigned CNT_WIDTH = 32)
`endif
  (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [3:0] State
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] CycCnt,
  output logic [CNT_WIDTH-1:0] RetCnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXR    = 4'd6,
    S_EXI    = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] CMD_CMP = 4'b1010;

  state_t     state_q;
  state_t     state_d;
  logic       alu_op;
  logic       branch;
  logic [3:0] cmd;

  assign cmd   = Funct[4:1];
  assign State = 4'(state_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and Moore outputs; reset overrides strobes and parks selects at FETCH values.
  always_comb begin
    state_d    = S_FETCH;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = Op;
    RegSrc     = {Op == 2'b01, Op == 2'b10};
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    alu_op     = 1'b0;
    branch     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXI : S_EXR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXR: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: RegW = (cmd != CMD_CMP);
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (alu_op) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        CMD_CMP: ALUControl = 2'b01;
        default: ALUControl = 2'b00;
      endcase
      // CV flags are only meaningful for arithmetic ops
      if (cmd == CMD_CMP) FlagW = 2'b11;
      else                FlagW = {Funct[0], Funct[0] & ~ALUControl[1]};
    end

    PCS = (RegW & (Rd == 4'hF)) | branch;

    if (reset) begin
      IRWrite    = 1'b0;
      NextPC     = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      PCS        = 1'b0;
      FlagW      = 2'b00;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b1;
      ALUSrcB    = 2'b10;
      ResultSrc  = 2'b10;
      ALUControl = 2'b00;
    end
  end

`ifdef MC_PERF_CNT_EN
  // Cycle and retired-instruction counters; retirement is any entry into FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      CycCnt <= '0;
      RetCnt <= '0;
    end else begin
      CycCnt <= CycCnt + CNT_WIDTH'(1);
      if (state_q != S_FETCH && state_d == S_FETCH) RetCnt <= RetCnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed and random instructions checked against a per-instruction model.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [3:0] State;
`ifdef MC_PERF_CNT_EN
  logic [31:0] CycCnt, RetCnt;
`endif

  int total = 0;
  int bad   = 0;
  int seq[$];
  logic [1:0] aluc_tab [16];

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .State(State)
`ifdef MC_PERF_CNT_EN
    , .CycCnt(CycCnt), .RetCnt(RetCnt)
`endif
  );

  // State walk of one instruction, by instruction class.
  function automatic void build_seq(input logic [1:0] op, input logic [5:0] fn);
    seq.delete();
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      2'b00: begin seq.push_back(fn[5] ? 7 : 6); seq.push_back(8); end
      2'b01: begin
        seq.push_back(2);
        if (fn[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b10: seq.push_back(9);
      default: ;
    endcase
  endfunction

  // Expected output bundle for a given state and instruction fields.
  function automatic logic [22:0] model(input int st, input logic [1:0] op, input logic [5:0] fn,
                                        input logic [3:0] rd, input logic rst);
    logic irw = 0, npc = 0, adr = 0, srca = 0, regw = 0, memw = 0, br = 0, pcs;
    logic [1:0] srcb = 0, res = 0, aluc = 0, flg = 0;
    logic [3:0] cmd;
    logic s;
    cmd = fn[4:1];
    s   = fn[0];
    case (st)
      0: begin srca = 1; srcb = 2'b10; res = 2'b10; irw = 1; npc = 1; end
      1: begin srca = 1; srcb = 2'b10; res = 2'b10; end
      2: srcb = 2'b01;
      3: adr = 1;
      4: begin res = 2'b01; regw = 1; end
      5: begin adr = 1; memw = 1; end
      6, 7: begin
        if (st == 7) srcb = 2'b01;
        aluc = aluc_tab[cmd];
        if (cmd == 4'b1010) flg = 2'b11;
        else flg = {s, s && (aluc == 2'b00 || aluc == 2'b01)};
      end
      8: regw = (cmd != 4'b1010);
      9: begin srcb = 2'b01; res = 2'b10; br = 1; end
      default: ;
    endcase
    pcs = (regw && rd == 4'd15) || br;
    if (rst) begin
      irw = 0; npc = 0; regw = 0; memw = 0; pcs = 0; flg = 0;
      adr = 0; srca = 1; srcb = 2'b10; res = 2'b10; aluc = 0;
    end
    return {4'(st), irw, npc, adr, srca, srcb, res, op, {op == 2'b01, op == 2'b10},
            aluc, flg, pcs, regw, memw};
  endfunction

  function automatic logic [22:0] observed();
    return {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
            ALUControl, FlagW, PCS, RegW, MemW};
  endfunction

  task automatic check(input string tag, input int st);
    logic [22:0] exp_v;
    logic [22:0] obs_v;
    exp_v = model(st, Op, Funct, Rd, reset);
    obs_v = observed();
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s st=%0d op=%b funct=%b rd=%0d observed=%h expected=%h",
             tag, st, Op, Funct, Rd, obs_v, exp_v);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge that starts the next FETCH.
  task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd);
    Op = op; Funct = fn; Rd = rd;
    build_seq(op, fn);
    foreach (seq[i]) begin
      #2;
      check(tag, seq[i]);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [1:0] rop;
    logic [5:0] rfn;
    logic [3:0] rrd;
    foreach (aluc_tab[i]) aluc_tab[i] = 2'b00;
    aluc_tab[4'b0100] = 2'b00;
    aluc_tab[4'b0010] = 2'b01;
    aluc_tab[4'b0000] = 2'b10;
    aluc_tab[4'b1100] = 2'b11;
    aluc_tab[4'b1010] = 2'b01;

    reset = 1'b1;
    Op = 2'(($urandom));
    Funct = 6'($urandom);
    Rd = 4'($urandom);
    @(negedge clk);
    #2 check("reset", 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 3; k++) run_instr("add", 2'b00, 6'b001000, 4'd3);
`ifdef MC_PERF_CNT_EN
    total++;
    assert (RetCnt === 32'd3) else begin
      bad++; $error("FAIL retcnt observed=%0d expected=3", RetCnt);
    end
    total++;
    assert (CycCnt === 32'd12) else begin
      bad++; $error("FAIL cyccnt observed=%0d expected=12", CycCnt);
    end
`endif

    run_instr("subs_imm", 2'b00, 6'b100101, 4'd2);
    run_instr("cmp",      2'b00, 6'b010101, 4'd15);
    run_instr("ands",     2'b00, 6'b000001, 4'd1);
    run_instr("ldr",      2'b01, 6'b011001, 4'd4);
    run_instr("str",      2'b01, 6'b011000, 4'd15);
    run_instr("ldr_pc",   2'b01, 6'b011001, 4'd15);
    run_instr("add_pc",   2'b00, 6'b001000, 4'd15);
    run_instr("branch",   2'b10, 6'b101010, 4'd0);
    run_instr("undef",    2'b11, 6'b111111, 4'd15);

    for (int n = 0; n < 80; n++) begin
      rop = 2'($urandom);
      rfn = 6'($urandom);
      rrd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr("random", rop, rfn, rrd);
    end

    // Abort a store while in MEMWR
    Op = 2'b01; Funct = 6'b000000; Rd = 4'd7;
    #2 check("str_abort", 0);
    @(negedge clk);
    #2 check("str_abort", 1);
    @(negedge clk);
    #2 check("str_abort", 2);
    @(negedge clk);
    reset = 1'b1;
    #2 check("rst_in_memwr", 5);
    total++;
    assert (MemW === 1'b0) else begin
      bad++; $error("FAIL rst_memw observed=%b expected=0", MemW);
    end
    @(negedge clk);
    #2 check("rst_next", 0);
    @(negedge clk);
    reset = 1'b0;
    run_instr("post_rst", 2'b00, 6'b011001, 4'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
